// File: rtl/conv_window_gen.sv
// Streaming FxF sliding-window generator (stride 1, no padding).
// Takes one CIN-channel pixel per beat in raster order. F-1 line buffers plus an
// FxF shift window build every complete window, which is handed to the consumer
// through a single valid/ready output register.
module conv_window_gen #(
    parameter int WIDTH = 8,
    parameter int CIN   = 3,
    parameter int F     = 5,
    parameter int IMG_W = 32,
    parameter int IMG_H = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH*CIN-1:0] in_data,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     x [0:CIN*F*F-1],
    output logic                 out_valid,
    output logic                 out_last,
    input  logic                 out_ready
);

    localparam int PW = WIDTH * CIN;
    localparam int NX = CIN * F * F;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_WIN  = CW'(F - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(F - 1);

    // Position counters of the next pixel to arrive
    logic [CW-1:0] col_q, col_d, pos_col;
    logic [RW-1:0] row_q, row_d, pos_row;

    // Window registers and line buffers: pure data, never reset
    logic [PW-1:0] win_q [0:F-1][0:F-1];
    logic [PW-1:0] win_d [0:F-1][0:F-1];
    logic [PW-1:0] lb_q  [0:F-2][0:IMG_W-1];

    // Output register
    logic             valid_q;
    logic             last_q;
    logic [WIDTH-1:0] x_q [0:NX-1];
    logic [WIDTH-1:0] x_d [0:NX-1];

    logic accept;
    logic emit;
    logic last_win;

    // The output register is the only storage stage, so ready is combinational
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // A start-of-frame beat is placed at (0,0) regardless of the counters
    assign pos_col  = in_sof ? '0 : col_q;
    assign pos_row  = in_sof ? '0 : row_q;

    assign emit     = accept && (pos_row >= ROW_WIN) && (pos_col >= COL_WIN);
    assign last_win = (pos_row == ROW_LAST) && (pos_col == COL_LAST);

    assign x         = x_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;

    // Next raster position after the accepted pixel, wrapping at frame end
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end
        end
    end

    // Window shifted left by one column with the new right column appended
    always_comb begin
        for (int i = 0; i < F; i++) begin
            for (int j = 0; j < F - 1; j++) begin
                win_d[i][j] = win_q[i][j+1];
            end
        end
        for (int i = 0; i < F - 1; i++) begin
            win_d[i][F-1] = lb_q[i][pos_col];
        end
        win_d[F-1][F-1] = in_data;
    end

    // Flatten the new window into channel-major, row, column layer ordering
    always_comb begin
        for (int ch = 0; ch < CIN; ch++) begin
            for (int i = 0; i < F; i++) begin
                for (int j = 0; j < F; j++) begin
                    x_d[(ch*F+i)*F+j] = win_d[i][j][ch*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Shift window and rotate the line-buffer column on every accepted beat
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_d;
            for (int k = 0; k < F - 2; k++) begin
                lb_q[k][pos_col] <= lb_q[k+1][pos_col];
            end
            lb_q[F-2][pos_col] <= in_data;
        end
    end

    // Raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Output register: load a completed window, otherwise clear once consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            for (int k = 0; k < NX; k++) begin
                x_q[k] <= '0;
            end
        end else if (emit) begin
            valid_q <= 1'b1;
            last_q  <= last_win;
            x_q     <= x_d;
        end else if (out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end

endmodule
